// File: rtl/wg_classifier_pkg.sv
// Shared constants, FSM state type and header classification helper for axis_wg_classifier.
package wg_classifier_pkg;

    localparam int unsigned HDR_LEN      = 38;
    localparam int unsigned CNT_W        = 6;
    localparam int unsigned MIN_ETH_LEN  = 14;

    localparam int unsigned OFF_ETYPE_HI = 12;
    localparam int unsigned OFF_ETYPE_LO = 13;
    localparam int unsigned OFF_VER_IHL  = 14;
    localparam int unsigned OFF_PROTO    = 23;
    localparam int unsigned OFF_DPORT_HI = 36;
    localparam int unsigned OFF_DPORT_LO = 37;

    localparam int unsigned DEST_CPU  = 0;
    localparam int unsigned DEST_WG   = 1;
    localparam int unsigned DEST_DROP = 3;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  IPV4_IHL5      = 8'h45;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_PASS    = 2'd2
    } state_e;

    // len is the number of header bytes seen (saturated at HDR_LEN).
    function automatic logic [1:0] classify(
        input logic [CNT_W-1:0] len,
        input logic [15:0]      etype,
        input logic [7:0]       ver_ihl,
        input logic [7:0]       proto,
        input logic [15:0]      dport,
        input logic [15:0]      wg_port
    );
        logic [1:0] code;
        code = 2'(DEST_DROP);
        if (len < CNT_W'(MIN_ETH_LEN)) begin
            code = 2'(DEST_DROP);
        end else if (etype == ETHERTYPE_ARP) begin
            code = 2'(DEST_CPU);
        end else if (etype == ETHERTYPE_IPV4) begin
            if (len == CNT_W'(HDR_LEN) && ver_ihl == IPV4_IHL5 &&
                proto == IP_PROTO_UDP && dport == wg_port) begin
                code = 2'(DEST_WG);
            end else begin
                code = 2'(DEST_CPU);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/wg_hdr_buf.sv
// Header byte buffer: in-order write/read of {data, last, user}, flushed once per frame.
module wg_hdr_buf
    import wg_classifier_pkg::*;
#(
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned DEPTH      = HDR_LEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic [7:0]             wr_data_i,
    input  logic                   wr_last_i,
    input  logic [USER_WIDTH-1:0]  wr_user_i,
    input  logic                   rd_en_i,
    input  logic                   flush_i,
    output logic [7:0]             rd_data_o,
    output logic                   rd_last_o,
    output logic [USER_WIDTH-1:0]  rd_user_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   empty_o
);

    logic [7:0]            data_q [DEPTH];
    logic                  last_q [DEPTH];
    logic [USER_WIDTH-1:0] user_q [DEPTH];
    logic [CNT_W-1:0]      wr_ptr_q, rd_ptr_q;

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_ptr_q] <= wr_data_i;
            last_q[wr_ptr_q] <= wr_last_i;
            user_q[wr_ptr_q] <= wr_user_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + CNT_W'(1);
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + CNT_W'(1);
        end
    end

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign empty_o   = (count_o == '0);
    assign rd_data_o = data_q[rd_ptr_q];
    assign rd_last_o = last_q[rd_ptr_q];
    assign rd_user_o = user_q[rd_ptr_q];

endmodule

// File: rtl/axis_wg_classifier.sv
// Buffers each frame's 38-byte header, classifies it (CPU/WG/drop) and re-emits it with a constant tdest.
// Optional WG_CLASSIFIER_STATS_EN adds per-class 32-bit frame counters.
module axis_wg_classifier
    import wg_classifier_pkg::*;
#(
    parameter logic [15:0] WG_UDP_PORT = 16'd51820,
    parameter int unsigned DEST_WIDTH  = 2,
    parameter int unsigned USER_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser
`ifdef WG_CLASSIFIER_STATS_EN
    ,
    output logic [31:0]           stat_wg,
    output logic [31:0]           stat_cpu,
    output logic [31:0]           stat_drop
`endif
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [15:0]           etype_q, etype_d, dport_q, dport_d;
    logic [7:0]            vihl_q, vihl_d, proto_q, proto_d;
    logic [DEST_WIDTH-1:0] dest_q;
    logic [1:0]            class_code;
    logic                  dest_load;

    logic                  buf_wr, buf_rd, buf_flush, buf_last, buf_empty;
    logic [7:0]            buf_data;
    logic [USER_WIDTH-1:0] buf_user;
    logic [CNT_W-1:0]      buf_count;

    wg_hdr_buf #(
        .USER_WIDTH (USER_WIDTH),
        .DEPTH      (HDR_LEN)
    ) u_hdr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (buf_wr),
        .wr_data_i (s_axis_tdata),
        .wr_last_i (s_axis_tlast),
        .wr_user_i (s_axis_tuser),
        .rd_en_i   (buf_rd),
        .flush_i   (buf_flush),
        .rd_data_o (buf_data),
        .rd_last_o (buf_last),
        .rd_user_o (buf_user),
        .count_o   (buf_count),
        .empty_o   (buf_empty)
    );

    // Field latches; the classifier sees the _d values so the byte accepted on exit is included.
    always_comb begin
        cnt_inc = (cnt_q == CNT_W'(HDR_LEN)) ? cnt_q : cnt_q + CNT_W'(1);
        etype_d = etype_q;
        vihl_d  = vihl_q;
        proto_d = proto_q;
        dport_d = dport_q;
        if (buf_wr) begin
            if (cnt_q == CNT_W'(OFF_ETYPE_HI)) etype_d[15:8] = s_axis_tdata;
            if (cnt_q == CNT_W'(OFF_ETYPE_LO)) etype_d[7:0]  = s_axis_tdata;
            if (cnt_q == CNT_W'(OFF_VER_IHL))  vihl_d        = s_axis_tdata;
            if (cnt_q == CNT_W'(OFF_PROTO))    proto_d       = s_axis_tdata;
            if (cnt_q == CNT_W'(OFF_DPORT_HI)) dport_d[15:8] = s_axis_tdata;
            if (cnt_q == CNT_W'(OFF_DPORT_LO)) dport_d[7:0]  = s_axis_tdata;
        end
        if (dest_load)   cnt_d = '0;
        else if (buf_wr) cnt_d = cnt_inc;
        else             cnt_d = cnt_q;
        class_code = classify(cnt_inc, etype_d, vihl_d, proto_d, dport_d, WG_UDP_PORT);
    end

    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        buf_wr        = 1'b0;
        buf_rd        = 1'b0;
        buf_flush     = 1'b0;
        dest_load     = 1'b0;
        unique case (state_q)
            ST_COLLECT: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    buf_wr = 1'b1;
                    if (s_axis_tlast || cnt_q == CNT_W'(HDR_LEN - 1)) begin
                        dest_load = 1'b1;
                        state_d   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                m_axis_tvalid = !buf_empty;
                m_axis_tdata  = buf_data;
                m_axis_tlast  = buf_last;
                m_axis_tuser  = buf_user;
                if (m_axis_tvalid && m_axis_tready) begin
                    buf_rd = 1'b1;
                    if (buf_count == CNT_W'(1)) begin
                        buf_flush = 1'b1;
                        state_d   = buf_last ? ST_COLLECT : ST_PASS;
                    end
                end
            end
            ST_PASS: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_d = ST_COLLECT;
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            etype_q <= '0;
            vihl_q  <= '0;
            proto_q <= '0;
            dport_q <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            etype_q <= etype_d;
            vihl_q  <= vihl_d;
            proto_q <= proto_d;
            dport_q <= dport_d;
            if (dest_load) dest_q <= DEST_WIDTH'(class_code);
        end
    end

    assign m_axis_tdest = dest_q;

`ifdef WG_CLASSIFIER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wg   <= '0;
            stat_cpu  <= '0;
            stat_drop <= '0;
        end else if (dest_load) begin
            if (class_code == 2'(DEST_WG))  stat_wg   <= stat_wg + 32'd1;
            if (class_code == 2'(DEST_CPU)) stat_cpu  <= stat_cpu + 32'd1;
            if (class_code == 2'(DEST_DROP)) stat_drop <= stat_drop + 32'd1;
        end
    end
`endif

endmodule
